keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 152 +++++++++++++++
 tb/tb_keypad_scanner.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one column at a time, debounces a single
// candidate key on press and release, and reports row*4+col on acceptance.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       system_clk,
    input  logic       rst_n,
    input  logic [3:0] Pad_Row,
    output logic [3:0] Pad_Col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned MATCH_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    logic [3:0]         row_meta;
    logic [3:0]         sync_row;
    logic [DIV_W-1:0]   dwell_cnt;
    state_t             state,     state_n;
    logic [1:0]         col_idx,   col_idx_n;
    logic [1:0]         cand_row,  cand_row_n;
    logic [1:0]         cand_col,  cand_col_n;
    logic [MATCH_W-1:0] match_cnt, match_n;
    logic [MATCH_W-1:0] match_inc;
    logic [3:0]         code_n;
    logic               valid_n;
    logic               held_n;
    logic               dwell_end;
    logic               cand_high;
    logic [1:0]         low_row;

    assign dwell_end = (dwell_cnt == DIV_LAST);
    assign cand_high = sync_row[cand_row];
    assign match_inc = (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + MATCH_W'(1);

    // Lowest-index active (low) row wins when several rows are pulled down
    always_comb begin
        low_row = 2'd0;
        if (!sync_row[0])      low_row = 2'd0;
        else if (!sync_row[1]) low_row = 2'd1;
        else if (!sync_row[2]) low_row = 2'd2;
        else if (!sync_row[3]) low_row = 2'd3;
    end

    always_comb begin
        state_n    = state;
        col_idx_n  = col_idx;
        cand_row_n = cand_row;
        cand_col_n = cand_col;
        match_n    = match_cnt;
        code_n     = key_code;
        valid_n    = 1'b0;
        held_n     = key_held;
        if (dwell_end) begin
            unique case (state)
                ST_SCAN: begin
                    if (sync_row == 4'hF) begin
                        col_idx_n = col_idx + 2'd1;
                    end else begin
                        cand_row_n = low_row;
                        cand_col_n = col_idx;
                        match_n    = MATCH_W'(1);
                        state_n    = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!cand_high) begin
                        if (match_inc == MATCH_MAX) begin
                            valid_n = 1'b1;
                            code_n  = {cand_row, cand_col};
                            held_n  = 1'b1;
                            match_n = '0;
                            state_n = ST_HELD;
                        end else begin
                            match_n = match_inc;
                        end
                    end else begin
                        match_n   = '0;
                        state_n   = ST_SCAN;
                        col_idx_n = cand_col + 2'd1;
                    end
                end
                ST_HELD: begin
                    if (cand_high) begin
                        match_n = MATCH_W'(1);
                        state_n = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (cand_high) begin
                        if (match_inc == MATCH_MAX) begin
                            held_n    = 1'b0;
                            match_n   = '0;
                            state_n   = ST_SCAN;
                            col_idx_n = cand_col + 2'd1;
                        end else begin
                            match_n = match_inc;
                        end
                    end else begin
                        match_n = '0;
                        state_n = ST_HELD;
                    end
                end
                default: state_n = ST_SCAN;
            endcase
        end
    end

    // Pad_Col is registered from the next column index so it tracks col_idx exactly
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta  <= 4'hF;
            sync_row  <= 4'hF;
            dwell_cnt <= '0;
            state     <= ST_SCAN;
            col_idx   <= 2'd0;
            cand_row  <= 2'd0;
            cand_col  <= 2'd0;
            match_cnt <= '0;
            Pad_Col   <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            row_meta  <= Pad_Row;
            sync_row  <= row_meta;
            dwell_cnt <= dwell_end ? '0 : dwell_cnt + DIV_W'(1);
            state     <= state_n;
            col_idx   <= col_idx_n;
            cand_row  <= cand_row_n;
            cand_col  <= cand_col_n;
            match_cnt <= match_n;
            Pad_Col   <= ~(4'b0001 << col_idx_n);
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives the rows from the column
// strobe; accepted keys are scoreboarded and checked whenever key_valid pulses.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEBOUNCE = 3;

    logic       system_clk = 1'b0;
    logic       rst_n;
    logic [3:0] Pad_Row;
    logic [3:0] Pad_Col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys;
    int unsigned bcnt;
    int          checks = 0;
    int          passes = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;
    logic [3:0]  one_hot;

    always #5 system_clk = ~system_clk;

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .system_clk(system_clk),
        .rst_n     (rst_n),
        .Pad_Row   (Pad_Row),
        .Pad_Col   (Pad_Col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Keypad matrix: a pressed key pulls its row low while its column is strobed
    always_comb begin
        Pad_Row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !Pad_Col[c]) Pad_Row[r] = 1'b0;
    end

    // Bench-side dwell phase, so stimulus changes land right after each sample point
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) bcnt <= 0;
        else        bcnt <= (bcnt == SCAN_DIV - 1) ? 0 : bcnt + 1;
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Advance to just after the next dwell-end edge (one sample)
    task automatic step();
        do @(negedge system_clk); while (bcnt != 0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: every key_valid pulse must match the oldest expected key
    always @(negedge system_clk) begin
        if (key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_key_valid: got key_code %h, no pulse expected", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                check("key_code_at_valid", key_code, mon_exp);
                check("key_held_at_valid", {3'b000, key_held}, 4'h1);
            end
        end
    end

    initial begin
        keys  = 16'h0000;
        rst_n = 1'b0;
        repeat (3) @(negedge system_clk);
        check("rst_pad_col", Pad_Col, 4'b1110);
        check("rst_key_code", key_code, 4'h0);
        check("rst_key_valid", {3'b000, key_valid}, 4'h0);
        check("rst_key_held", {3'b000, key_held}, 4'h0);
        rst_n = 1'b1;

        // Idle scan: column strobe rotates every SCAN_DIV cycles
        for (int k = 1; k <= 64; k++) begin
            @(negedge system_clk);
            one_hot = 4'b0001 << ((k / 4) % 4);
            check("idle_scan_col", Pad_Col, ~one_hot);
        end

        // Row 2 / col 1 pressed steadily
        keys[9] = 1'b1;
        exp_q.push_back(4'h9);
        steps(4);
        check("press_held", {3'b000, key_held}, 4'h1);
        check("press_col_frozen", Pad_Col, 4'b1101);
        steps(3);
        check("hold_held", {3'b000, key_held}, 4'h1);
        check("hold_col_frozen", Pad_Col, 4'b1101);

        // Clean release
        keys = 16'h0000;
        step();
        check("rel1_held", {3'b000, key_held}, 4'h1);
        step();
        check("rel2_held", {3'b000, key_held}, 4'h1);
        step();
        check("rel3_held", {3'b000, key_held}, 4'h0);
        check("rel3_scan_col", Pad_Col, 4'b1011);

        // Bouncing press on row 0 / col 2: one low sample, then high
        keys[2] = 1'b1;
        step();
        check("bounce_col_frozen", Pad_Col, 4'b1011);
        keys = 16'h0000;
        step();
        check("bounce_scan_col", Pad_Col, 4'b0111);
        check("bounce_held", {3'b000, key_held}, 4'h0);

        // Row 3 / col 3 with a release glitch (high, high, low)
        keys[15] = 1'b1;
        exp_q.push_back(4'hF);
        steps(3);
        check("glitch_press_held", {3'b000, key_held}, 4'h1);
        keys = 16'h0000;
        steps(2);
        check("glitch_mid_held", {3'b000, key_held}, 4'h1);
        keys[15] = 1'b1;
        step();
        check("glitch_back_held", {3'b000, key_held}, 4'h1);
        check("glitch_col_frozen", Pad_Col, 4'b0111);
        steps(2);
        check("glitch_still_held", {3'b000, key_held}, 4'h1);
        keys = 16'h0000;
        steps(3);
        check("glitch_rel_held", {3'b000, key_held}, 4'h0);
        check("glitch_rel_col", Pad_Col, 4'b1110);

        // Rows 1 and 3 both low on column 0: lowest row wins
        keys[4]  = 1'b1;
        keys[12] = 1'b1;
        exp_q.push_back(4'h4);
        steps(3);
        check("multi_key_code", key_code, 4'h4);
        keys = 16'h0000;
        steps(3);
        check("multi_rel_col", Pad_Col, 4'b1101);

        // Reset asserted mid-debounce of row 0 / col 1
        keys[1] = 1'b1;
        steps(2);
        @(negedge system_clk);
        rst_n = 1'b0;
        keys  = 16'h0000;
        @(negedge system_clk);
        check("abort_pad_col", Pad_Col, 4'b1110);
        check("abort_key_code", key_code, 4'h0);
        check("abort_key_valid", {3'b000, key_valid}, 4'h0);
        check("abort_key_held", {3'b000, key_held}, 4'h0);
        repeat (2) @(negedge system_clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge system_clk);
            check("restart_col0", Pad_Col, 4'b1110);
        end
        @(negedge system_clk);
        check("restart_col1", Pad_Col, 4'b1101);
        steps(4);

        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL scoreboard_drained: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
